// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, commit flag bit
// positions and the exception priority encoder.
package cp0_unit_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   localparam int EXB_ADEL_F = 6;
   localparam int EXB_RI     = 5;
   localparam int EXB_OV     = 4;
   localparam int EXB_SYS    = 3;
   localparam int EXB_BP     = 2;
   localparam int EXB_ADEL_D = 1;
   localparam int EXB_ADES   = 0;

   // BEV is hardwired; it is the only fixed bit in Status.
   localparam logic [31:0] STATUS_BEV = 32'h0040_0000;

   function automatic logic [4:0] exc_code_sel(input logic int_pend, input logic [6:0] exc);
      logic [4:0] code;
      if (int_pend)               code = EXC_INT;
      else if (exc[EXB_ADEL_F])   code = EXC_ADEL;
      else if (exc[EXB_RI])       code = EXC_RI;
      else if (exc[EXB_OV])       code = EXC_OV;
      else if (exc[EXB_SYS])      code = EXC_SYS;
      else if (exc[EXB_BP])       code = EXC_BP;
      else if (exc[EXB_ADEL_D])   code = EXC_ADEL;
      else if (exc[EXB_ADES])     code = EXC_ADES;
      else                        code = EXC_INT;
      return code;
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Commit-point, MTC0/MFC0 and redirect signals between pipeline and CP0.
interface cp0_unit_if;
   logic        cm_valid;
   logic [31:0] cm_pc;
   logic        cm_bd;
   logic [31:0] cm_badvaddr;
   logic [6:0]  cm_exc;
   logic        cm_eret;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic [4:0]  mfc0_addr;
   logic [31:0] mfc0_rdata;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      output cm_valid, cm_pc, cm_bd, cm_badvaddr, cm_exc, cm_eret,
      output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
      input  mfc0_rdata, flush, flush_pc
   );

   modport slave (
      input  cm_valid, cm_pc, cm_bd, cm_badvaddr, cm_exc, cm_eret,
      input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
      output mfc0_rdata, flush, flush_pc
   );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count advances on every second clock; TI latches one
// cycle after Count equals Compare and is cleared only by a Compare write.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic tick;

   // Tick toggle, count increment (a write overrides the tick), compare match latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick    <= 1'b0;
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
      end else begin
         tick <= ~tick;
         if (count_we)
            count <= wdata;
         else if (tick)
            count <= count + 32'd1;
         if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (count == compare) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// CP0 system control: exception/interrupt arbitration at commit, ERET,
// MTC0/MFC0 register file and pipeline redirect.
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   cp0_unit_if.slave   bus,
   output logic        status_exl,
   output logic [31:0] epc
);

   logic [7:0]  status_im;
   logic        status_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exc;
   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   logic        int_pending;
   logic        exc_take;
   logic        eret_take;
   logic        mtc0_ok;
   logic [4:0]  exc_code;
   logic [31:0] status_val;
   logic [31:0] cause_val;

   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (mtc0_ok && (bus.mtc0_addr == CP0_COUNT)),
      .compare_we (mtc0_ok && (bus.mtc0_addr == CP0_COMPARE)),
      .wdata      (bus.mtc0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   // Event arbitration and redirect; reset kills any event in the same cycle.
   always_comb begin
      int_pending  = status_ie & ~status_exl & (|({cause_ip_hw, cause_ip_sw} & status_im));
      exc_take     = ~reset & bus.cm_valid & (int_pending | (|bus.cm_exc));
      eret_take    = ~reset & bus.cm_valid & bus.cm_eret & ~exc_take;
      exc_code     = exc_code_sel(int_pending, bus.cm_exc);
      mtc0_ok      = bus.mtc0_we & ~exc_take & ~eret_take;
      bus.flush    = exc_take | eret_take;
      bus.flush_pc = exc_take ? EXC_VECTOR : epc;
   end

   // Register read mux (pre-edge state, no write bypass).
   always_comb begin
      status_val = STATUS_BEV | {16'd0, status_im, 6'd0, status_exl, status_ie};
      cause_val  = {cause_bd, ti, 14'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};
      case (bus.mfc0_addr)
         CP0_BADVADDR: bus.mfc0_rdata = badvaddr;
         CP0_COUNT:    bus.mfc0_rdata = count;
         CP0_COMPARE:  bus.mfc0_rdata = compare;
         CP0_STATUS:   bus.mfc0_rdata = status_val;
         CP0_CAUSE:    bus.mfc0_rdata = cause_val;
         CP0_EPC:      bus.mfc0_rdata = epc;
         default:      bus.mfc0_rdata = 32'd0;
      endcase
   end

   // Status/Cause/EPC/BadVAddr update: exception, then ERET, then MTC0.
   always_ff @(posedge clk) begin
      if (reset) begin
         status_im   <= 8'd0;
         status_exl  <= 1'b0;
         status_ie   <= 1'b0;
         cause_bd    <= 1'b0;
         cause_ip_hw <= 6'd0;
         cause_ip_sw <= 2'd0;
         cause_exc   <= 5'd0;
         epc         <= 32'd0;
         badvaddr    <= 32'd0;
      end else begin
         cause_ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
         if (exc_take) begin
            status_exl <= 1'b1;
            cause_exc  <= exc_code;
            // Nested exceptions keep the original return point.
            if (!status_exl) begin
               epc      <= bus.cm_bd ? bus.cm_pc - 32'd4 : bus.cm_pc;
               cause_bd <= bus.cm_bd;
            end
            if ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES))
               badvaddr <= bus.cm_badvaddr;
         end else if (eret_take) begin
            status_exl <= 1'b0;
         end else if (mtc0_ok) begin
            case (bus.mtc0_addr)
               CP0_STATUS: begin
                  status_im  <= bus.mtc0_wdata[15:8];
                  status_exl <= bus.mtc0_wdata[1];
                  status_ie  <= bus.mtc0_wdata[0];
               end
               CP0_CAUSE: cause_ip_sw <= bus.mtc0_wdata[9:8];
               CP0_EPC:   epc <= bus.mtc0_wdata;
               default:   ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, timer interrupt, exceptions, ERET, MTC0.
module tb_cp0_unit;
   import cp0_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hw_int;
   logic        status_exl;
   logic [31:0] epc;
   int          n_chk = 0;
   int          n_err = 0;

   cp0_unit_if bus ();

   cp0_unit #(.EXC_VECTOR(32'hBFC00380)) dut (
      .clk        (clk),
      .reset      (reset),
      .hw_int     (hw_int),
      .bus        (bus),
      .status_exl (status_exl),
      .epc        (epc)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      bus.mfc0_addr = a;
      #1;
      chk(tag, bus.mfc0_rdata, exp);
   endtask

   task automatic idle();
      bus.cm_valid    = 1'b0;
      bus.cm_pc       = 32'd0;
      bus.cm_bd       = 1'b0;
      bus.cm_badvaddr = 32'd0;
      bus.cm_exc      = 7'd0;
      bus.cm_eret     = 1'b0;
      bus.mtc0_we     = 1'b0;
      bus.mtc0_addr   = 5'd0;
      bus.mtc0_wdata  = 32'd0;
      bus.mfc0_addr   = 5'd0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                         input logic [6:0] exc);
      bus.cm_valid    = 1'b1;
      bus.cm_pc       = pc;
      bus.cm_bd       = bd;
      bus.cm_badvaddr = bva;
      bus.cm_exc      = exc;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.mtc0_we    = 1'b1;
      bus.mtc0_addr  = a;
      bus.mtc0_wdata = d;
   endtask

   initial begin
      reset  = 1'b1;
      hw_int = 6'd0;
      idle();
      repeat (3) cycle();

      chk("rst_flush", {31'd0, bus.flush}, 32'd0);
      chk("rst_exl", {31'd0, status_exl}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      rd("rst_status", CP0_STATUS, 32'h0040_0000);
      rd("rst_cause", CP0_CAUSE, 32'd0);
      rd("rst_count", CP0_COUNT, 32'd0);
      rd("rst_compare", CP0_COMPARE, 32'd0);
      rd("rst_badvaddr", CP0_BADVADDR, 32'd0);
      rd("unimpl_addr", 5'd31, 32'd0);

      // Sys committing while reset is held: no flush, nothing recorded.
      commit(32'hBFC00100, 1'b0, 32'd0, 7'h08);
      #1;
      chk("rst_sys_flush", {31'd0, bus.flush}, 32'd0);
      cycle();
      idle();
      chk("rst_sys_exl", {31'd0, status_exl}, 32'd0);
      chk("rst_sys_epc", epc, 32'd0);
      rd("rst_sys_cause", CP0_CAUSE, 32'd0);

      // Timer interrupt: Compare=5, IE=1, IM7=1.
      reset = 1'b0;
      mtc0(CP0_COMPARE, 32'd5);
      cycle();                                   // edge 1
      idle();
      mtc0(CP0_STATUS, 32'h0000_8001);
      cycle();                                   // edge 2
      idle();
      rd("tmr_status", CP0_STATUS, 32'h0040_8001);
      repeat (8) cycle();                        // edge 10
      rd("tmr_count5", CP0_COUNT, 32'd5);
      rd("tmr_cause_e10", CP0_CAUSE, 32'd0);
      cycle();                                   // edge 11
      rd("tmr_ti_set", CP0_CAUSE, 32'h4000_0000);
      cycle();                                   // edge 12
      rd("tmr_ip7", CP0_CAUSE, 32'h4000_8000);
      rd("tmr_count6", CP0_COUNT, 32'd6);
      commit(32'h8000_0100, 1'b0, 32'd0, 7'h00);
      #1;
      chk("int_flush", {31'd0, bus.flush}, 32'd1);
      chk("int_flush_pc", bus.flush_pc, 32'hBFC00380);
      cycle();                                   // edge 13
      idle();
      chk("int_exl", {31'd0, status_exl}, 32'd1);
      chk("int_epc", epc, 32'h8000_0100);
      rd("int_cause", CP0_CAUSE, 32'h4000_8000);
      rd("int_status", CP0_STATUS, 32'h0040_8003);
      mtc0(CP0_COMPARE, 32'd100);
      cycle();                                   // edge 14
      idle();
      rd("ti_clear", CP0_CAUSE, 32'h0000_8000);
      rd("tmr_count7", CP0_COUNT, 32'd7);

      // No commit: flags and ERET ignored, MTC0 Status goes through.
      bus.cm_exc  = 7'h7f;
      bus.cm_eret = 1'b1;
      mtc0(CP0_STATUS, 32'd0);
      #1;
      chk("novalid_flush", {31'd0, bus.flush}, 32'd0);
      cycle();
      idle();
      chk("novalid_exl", {31'd0, status_exl}, 32'd0);
      rd("ip7_clear", CP0_CAUSE, 32'd0);
      rd("status_cleared", CP0_STATUS, 32'h0040_0000);

      // Syscall.
      commit(32'hBFC00100, 1'b0, 32'h5555_5555, 7'h08);
      #1;
      chk("sys_flush", {31'd0, bus.flush}, 32'd1);
      chk("sys_flush_pc", bus.flush_pc, 32'hBFC00380);
      cycle();
      idle();
      #1;
      chk("flush_pulse", {31'd0, bus.flush}, 32'd0);
      chk("sys_exl", {31'd0, status_exl}, 32'd1);
      chk("sys_epc", epc, 32'hBFC00100);
      rd("sys_cause", CP0_CAUSE, 32'h0000_0020);
      rd("sys_badvaddr", CP0_BADVADDR, 32'd0);

      // Nested breakpoint with EXL=1.
      commit(32'h1234_5678, 1'b0, 32'd0, 7'h04);
      #1;
      chk("nest_flush", {31'd0, bus.flush}, 32'd1);
      cycle();
      idle();
      chk("nest_epc", epc, 32'hBFC00100);
      rd("nest_cause", CP0_CAUSE, 32'h0000_0024);

      // EPC write, read before the edge shows the old value.
      mtc0(CP0_EPC, 32'h8000_0010);
      rd("epc_no_bypass", CP0_EPC, 32'hBFC00100);
      cycle();
      idle();
      chk("epc_write", epc, 32'h8000_0010);

      // ERET with a competing MTC0 Status.
      bus.cm_valid = 1'b1;
      bus.cm_eret  = 1'b1;
      mtc0(CP0_STATUS, 32'h0000_FF01);
      #1;
      chk("eret_flush", {31'd0, bus.flush}, 32'd1);
      chk("eret_flush_pc", bus.flush_pc, 32'h8000_0010);
      cycle();
      idle();
      chk("eret_exl", {31'd0, status_exl}, 32'd0);
      rd("eret_mtc0_supp", CP0_STATUS, 32'h0040_0000);

      // AdEL-fetch + Ov in a delay slot.
      commit(32'h8000_1004, 1'b1, 32'h8000_1006, 7'h50);
      cycle();
      idle();
      rd("adel_cause", CP0_CAUSE, 32'h8000_0010);
      chk("adel_epc", epc, 32'h8000_1000);
      rd("adel_badvaddr", CP0_BADVADDR, 32'h8000_1006);
      chk("adel_exl", {31'd0, status_exl}, 32'd1);

      // RI beats Sys.
      commit(32'h0000_0040, 1'b0, 32'd0, 7'h28);
      cycle();
      idle();
      rd("ri_cause", CP0_CAUSE, 32'h8000_0028);

      // AdES updates BadVAddr, EPC held.
      commit(32'h0000_0080, 1'b0, 32'hDEAD_0001, 7'h01);
      cycle();
      idle();
      rd("ades_cause", CP0_CAUSE, 32'h8000_0014);
      rd("ades_badvaddr", CP0_BADVADDR, 32'hDEAD_0001);
      chk("ades_epc", epc, 32'h8000_1000);

      // Sys must leave BadVAddr alone.
      commit(32'h0000_00C0, 1'b0, 32'h1111_1111, 7'h08);
      cycle();
      idle();
      rd("sys_keep_bva", CP0_BADVADDR, 32'hDEAD_0001);

      // Count write and wrap.
      mtc0(CP0_COUNT, 32'hFFFF_FFFF);
      cycle();
      idle();
      rd("count_write", CP0_COUNT, 32'hFFFF_FFFF);
      repeat (2) cycle();
      rd("count_wrap", CP0_COUNT, 32'd0);

      // Software IP bits only.
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      cycle();
      idle();
      rd("cause_sw_ip", CP0_CAUSE, 32'h8000_0320);

      // Hardware lines.
      hw_int = 6'b100001;
      cycle();
      rd("cause_hw_ip", CP0_CAUSE, 32'h8000_8720);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter: EXC_VECTOR, 32'hBFC00380, exception entry PC.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high.
REQ-004 SHALL have port: cm_valid  in  1  instruction at commit point valid this cycle.
REQ-005 SHALL have port: cm_pc  in  32  PC of committing instruction.
REQ-006 SHALL have port: cm_bd  in  1  committing instruction sits in a delay slot.
REQ-007 SHALL have port: cm_badvaddr  in  32  faulting address (fetch PC or data address).
REQ-008 SHALL have port: cm_exc  in  7  flags [6]AdEL-fetch [5]RI [4]Ov [3]Sys [2]Bp [1]AdEL-data [0]AdES.
REQ-009 SHALL have port: cm_eret  in  1  committing ERET.
REQ-010 SHALL have port: mtc0_we, mtc0_addr, mtc0_wdata  in  1/5/32  CP0 write (rd field).
REQ-011 SHALL have port: mfc0_addr  in  5; mfc0_rdata  out  32  combinational CP0 read.
REQ-012 SHALL have port: hw_int  in  6  external interrupt lines, level.
REQ-013 SHALL have ports: status_exl  out  1; epc  out  32  (feed decode ERET/MTC0 checks).
REQ-014 SHALL have ports: flush  out  1; flush_pc  out  32  pipeline redirect.

Function
REQ-015 Registers implemented: BadVAddr(8), Count(9), Compare(11), Status(12: IM[15:8], EXL[1], IE[0]), Cause(13: BD[31], TI[30], IP[15:8], ExcCode[6:2]), EPC(14); other addresses read 0.
REQ-016 Count SHALL increment by 1 every second cycle via internal tick toggle; wraps 32'hFFFFFFFF->0.
REQ-017 Cause.TI SHALL set the cycle after Count==Compare; cleared by MTC0 to Compare.
REQ-018 Cause.IP[15:10] SHALL register {hw_int[5] | TI, hw_int[4:0]} each cycle; IP[9:8] software-writable only.
REQ-019 int_pending = IE & ~EXL & |(IP & IM); taken only when cm_valid=1.
REQ-020 Priority when cm_valid: Int(0x00) > AdEL-fetch(0x04) > RI(0x0a) > Ov(0x0c) > Sys(0x08) > Bp(0x09) > AdEL-data(0x04) > AdES(0x05).
REQ-021 On taking exception (edge): EXL<=1, ExcCode<=code, and if EXL was 0: EPC<=cm_bd?cm_pc-4:cm_pc, BD<=cm_bd; BadVAddr<=cm_badvaddr only for AdEL/AdES.
REQ-022 Exception SHALL assert flush=1, flush_pc=EXC_VECTOR combinationally in the same cycle; latency 0, one-cycle pulse per event.
REQ-023 ERET (cm_valid, no exception): EXL<=0, flush=1, flush_pc=EPC (pre-update value).
REQ-024 MTC0 SHALL be suppressed in a cycle where an exception or ERET is taken; writable fields only (Count, Compare, Status IM/EXL/IE, Cause IP[9:8], EPC).
REQ-025 MTC0 to Count same cycle as tick: written value wins.
REQ-026 mfc0_rdata SHALL reflect register state before the current edge (no write bypass).
REQ-027 cm_valid=0: no exception, ERET, or flush regardless of flags.

Reset
REQ-028 On reset: Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0), Cause=0, Count=0, Compare=0, EPC=0, BadVAddr=0, tick=0.
REQ-029 Reset outputs: flush=0, status_exl=0, epc=0, mfc0_rdata per address of reset values.
REQ-030 Reset mid-exception SHALL discard the event; no register updated that edge.

Structure
REQ-031 CP0 register addresses, ExcCode constants, and cm_exc bit indices SHALL live in the shared package/include beside the decode list.
REQ-032 One sub-module cp0_timer (Count, Compare, tick, TI) SHALL be instantiated; all else in cp0_unit.

Verification
REQ-033 Sys at cm_pc=32'hBFC00100, bd=0 -> flush=1, flush_pc=BFC00380, EPC=BFC00100, ExcCode=0x08, EXL=1.
REQ-034 AdEL-fetch + Ov together, bd=1, pc=32'h80001004, badvaddr=32'h80001006 -> ExcCode=0x04, EPC=80001000, BD=1, BadVAddr=80001006.
REQ-035 Compare=5, Status IE=1 IM7=1 -> TI set after Count reaches 5 (cycle 10); next cm_valid takes Int; MTC0 Compare clears TI.
REQ-036 ERET with EPC=32'h80000010 -> flush_pc=80000010, EXL=0; simultaneous MTC0 Status suppressed.
REQ-037 Second exception with EXL=1 -> EPC unchanged, ExcCode updated, flush asserted.
REQ-038 Reset asserted same cycle as Sys -> all registers at reset values, flush=0.
